gmii_tx_scheduler: RTL and testbench

- Sequences the GMII transmit interface (TX_EN, TX_ER, TXD) that feeds the PCS TRANSMIT/ENCODE path.
- Arbitrates between two frame sources round-robin and inserts preamble and SFD.
- Streams payload bytes, propagates source errors and underruns as TX_ER, and enforces the minimum inter-packet gap.
- Holds off a new frame until the PCS reports transmitting low.

---
 rtl/gmii_tx_scheduler.sv | 148 ++++++++++++++
 tb/tb_gmii_tx_scheduler.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_scheduler.sv
// GMII transmit scheduler: round-robin arbitration between two byte sources,
// preamble/SFD insertion, underrun/error signalling on TX_ER and inter-packet gap.
module gmii_tx_scheduler #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IPG_MIN      = 12
) (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  input  logic       req0_err,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  input  logic       req1_err,
  output logic       req1_ready,
  input  logic       transmitting,
  output logic       TX_EN,
  output logic       TX_ER,
  output logic [7:0] TXD,
  output logic [1:0] grant,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_IPG} state_t;

  state_t     r_state;
  logic [3:0] r_pre_cnt;
  logic [7:0] r_ipg_cnt;
  logic       r_ptr;
  logic       r_eof;
  logic       r_tx_en;
  logic       r_tx_er;
  logic [7:0] r_txd;
  logic [1:0] r_grant;
  logic       r_frame_done;
  logic       r_underrun;

  logic       w_vld;
  logic       w_last;
  logic       w_err;
  logic [7:0] w_data;
  logic       w_rdy;
  logic       w_win1;
  logic       w_gap_ok;
  logic       w_start;
  logic [8:0] w_ipg_inc;

  // Payload handshake is muxed from whichever source currently owns the link
  assign w_vld  = r_grant[1] ? req1_valid : req0_valid;
  assign w_last = r_grant[1] ? req1_last  : req0_last;
  assign w_err  = r_grant[1] ? req1_err   : req0_err;
  assign w_data = r_grant[1] ? req1_data  : req0_data;

  assign w_rdy      = (r_state == S_SFD) || ((r_state == S_DATA) && !r_eof);
  assign req0_ready = w_rdy & r_grant[0];
  assign req1_ready = w_rdy & r_grant[1];

  // Starting straight from the last IPG cycle keeps the idle gap at exactly IPG_MIN
  assign w_ipg_inc = {1'b0, r_ipg_cnt} + 9'd1;
  assign w_gap_ok  = ((r_state == S_IDLE) && (r_ipg_cnt == 8'(IPG_MIN))) ||
                     ((r_state == S_IPG) && (w_ipg_inc >= 9'(IPG_MIN)));
  assign w_start   = (req0_valid | req1_valid) & ~transmitting & w_gap_ok;
  assign w_win1    = r_ptr ? req1_valid : ~req0_valid;

  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      r_state      <= S_IDLE;
      r_pre_cnt    <= 4'd0;
      r_ipg_cnt    <= 8'(IPG_MIN);
      r_ptr        <= 1'b0;
      r_eof        <= 1'b0;
      r_tx_en      <= 1'b0;
      r_tx_er      <= 1'b0;
      r_txd        <= 8'h00;
      r_grant      <= 2'b00;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_start) begin
        r_state    <= S_PRE;
        r_pre_cnt  <= 4'd1;
        r_grant    <= w_win1 ? 2'b10 : 2'b01;
        r_tx_en    <= 1'b1;
        r_tx_er    <= 1'b0;
        r_txd      <= 8'h55;
        r_underrun <= 1'b0;
        r_eof      <= 1'b0;
      end else begin
        case (r_state)
          S_PRE: begin
            if (r_pre_cnt == 4'(PREAMBLE_LEN)) begin
              r_state <= S_SFD;
              r_txd   <= 8'hD5;
            end else begin
              r_pre_cnt <= r_pre_cnt + 4'd1;
            end
          end
          S_SFD, S_DATA: begin
            if (r_eof) begin
              r_state      <= S_IPG;
              r_tx_en      <= 1'b0;
              r_tx_er      <= 1'b0;
              r_txd        <= 8'h00;
              r_grant      <= 2'b00;
              r_frame_done <= 1'b1;
              r_ptr        <= r_grant[0];
              r_ipg_cnt    <= 8'd0;
              r_eof        <= 1'b0;
            end else begin
              r_state <= S_DATA;
              if (w_vld) begin
                r_txd   <= w_data;
                r_tx_er <= w_err;
                r_eof   <= w_last;
              end else begin
                r_txd      <= 8'h00;
                r_tx_er    <= 1'b1;
                r_underrun <= 1'b1;
              end
            end
          end
          S_IPG: begin
            if (w_ipg_inc >= 9'(IPG_MIN)) begin
              r_ipg_cnt <= 8'(IPG_MIN);
              if (!transmitting) r_state <= S_IDLE;
            end else begin
              r_ipg_cnt <= w_ipg_inc[7:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign TX_EN      = r_tx_en;
  assign TX_ER      = r_tx_er;
  assign TXD        = r_txd;
  assign grant      = r_grant;
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_gmii_tx_scheduler.sv
// Bench for gmii_tx_scheduler: scripted and random frames checked against a
// frame-level model (expected byte stream, round-robin order, gap length).
module tb_gmii_tx_scheduler;
  localparam int PRE = 7;
  localparam int IPG = 12;

  logic       GTX_CLK = 1'b0;
  logic       mr_main_reset;
  logic       req0_valid, req0_last, req0_err, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_err, req1_ready;
  logic [7:0] req1_data;
  logic       transmitting;
  logic       TX_EN, TX_ER, frame_done, underrun;
  logic [7:0] TXD;
  logic [1:0] grant;

  gmii_tx_scheduler #(.PREAMBLE_LEN(PRE), .IPG_MIN(IPG)) dut (
    .GTX_CLK(GTX_CLK), .mr_main_reset(mr_main_reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last),
    .req0_err(req0_err), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last),
    .req1_err(req1_err), .req1_ready(req1_ready),
    .transmitting(transmitting),
    .TX_EN(TX_EN), .TX_ER(TX_ER), .TXD(TXD), .grant(grant),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #5 GTX_CLK = ~GTX_CLK;

  typedef struct packed {
    logic             src;
    logic [3:0]       len;
    logic [15:0][7:0] d;
    logic [15:0]      e;
    logic [15:0][1:0] g;   // stall cycles the source inserts before byte j
  } frame_t;

  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] d;
    logic [1:0] gnt;
    logic       fd;
    logic       ur;
  } smp_t;

  frame_t     q0[$], q1[$], L0[$], L1[$];
  smp_t       lg[$];
  logic [8:0] ew[$];
  int         bi0, bi1, gr0, gr1;
  logic       model_ptr;
  int         checks = 0;
  int         errors = 0;

  function automatic frame_t mk(logic src, int len, logic [7:0] base, logic [7:0] step);
    frame_t f;
    f = '0;
    f.src = src;
    f.len = 4'(len);
    for (int i = 0; i < len; i++) f.d[i] = base + 8'(i) * step;
    return f;
  endfunction

  task automatic load(input frame_t f);
    if (f.src) begin q1.push_back(f); L1.push_back(f); end
    else       begin q0.push_back(f); L0.push_back(f); end
  endtask

  task automatic begin_run();
    L0.delete(); L1.delete(); lg.delete();
  endtask

  task automatic flush_srcs();
    q0.delete(); q1.delete();
    bi0 = 0; bi1 = 0; gr0 = 0; gr1 = 0;
  endtask

  task automatic drive_srcs();
    if (q0.size() > 0 && gr0 == 0) begin
      req0_valid = 1'b1; req0_data = q0[0].d[bi0];
      req0_last = (bi0 == int'(q0[0].len) - 1); req0_err = q0[0].e[bi0];
    end else begin
      req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0; req0_err = 1'b0;
    end
    if (q1.size() > 0 && gr1 == 0) begin
      req1_valid = 1'b1; req1_data = q1[0].d[bi1];
      req1_last = (bi1 == int'(q1[0].len) - 1); req1_err = q1[0].e[bi1];
    end else begin
      req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0; req1_err = 1'b0;
    end
  endtask

  task automatic acct();
    checks++;
    if (req0_ready && req1_ready) begin
      errors++;
      $display("FAIL ready_exclusive: got both readies high, required at most one");
    end
    if (req0_valid && req0_ready) begin
      bi0++;
      if (bi0 == int'(q0[0].len)) begin void'(q0.pop_front()); bi0 = 0; gr0 = 0; end
      else gr0 = int'(q0[0].g[bi0]);
    end else if (req0_ready && !req0_valid && gr0 > 0) gr0--;
    if (req1_valid && req1_ready) begin
      bi1++;
      if (bi1 == int'(q1[0].len)) begin void'(q1.pop_front()); bi1 = 0; gr1 = 0; end
      else gr1 = int'(q1[0].g[bi1]);
    end else if (req1_ready && !req1_valid && gr1 > 0) gr1--;
  endtask

  task automatic cycle();
    smp_t s;
    drive_srcs();
    #1;
    acct();
    @(posedge GTX_CLK);
    #1;
    s.en = TX_EN; s.er = TX_ER; s.d = TXD; s.gnt = grant; s.fd = frame_done; s.ur = underrun;
    lg.push_back(s);
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin cycle(); n++; end
    checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL run_timeout: got %0d frames still queued, required 0", q0.size() + q1.size());
    end
    repeat (3) cycle();
  endtask

  task automatic apply_reset();
    mr_main_reset = 1'b0;
    transmitting  = 1'b0;
    flush_srcs();
    drive_srcs();
    @(posedge GTX_CLK);
    #1;
    mr_main_reset = 1'b1;
    model_ptr = 1'b0;
  endtask

  // Frame-level model: round-robin order from the loaded frames, then the
  // expected TX stream per frame, compared with the captured samples.
  task automatic check_frames(input string nm, input bit chk_gap, input bit chk_lat);
    frame_t a[$], b[$], ord[$];
    frame_t f;
    int i, k, st, en_, last_end, bad, first, gb, fdn, nobs;
    logic [1:0] eg;
    a = L0; b = L1;
    while (a.size() > 0 || b.size() > 0) begin
      if ((model_ptr == 1'b0 && a.size() > 0) || (model_ptr == 1'b1 && b.size() == 0)) begin
        ord.push_back(a.pop_front()); model_ptr = 1'b1;
      end else begin
        ord.push_back(b.pop_front()); model_ptr = 1'b0;
      end
    end
    i = 0; k = 0; last_end = -1;
    while (i < lg.size()) begin
      if (!lg[i].en) begin i++; continue; end
      st = i;
      while (i < lg.size() && lg[i].en) i++;
      en_ = i - 1;
      if (k >= ord.size()) begin
        checks++; errors++;
        $display("FAIL %s extra_frame: got frame %0d at sample %0d, required %0d frames", nm, k, st, ord.size());
        k++;
        continue;
      end
      f = ord[k];
      ew.delete();
      for (int p = 0; p < PRE; p++) ew.push_back({1'b0, 8'h55});
      ew.push_back({1'b0, 8'hD5});
      for (int j = 0; j < int'(f.len); j++) begin
        for (int t = 0; t < int'(f.g[j]); t++) ew.push_back({1'b1, 8'h00});
        ew.push_back({f.e[j], f.d[j]});
      end
      nobs = en_ - st + 1;
      checks++;
      if (nobs != ew.size()) begin
        errors++;
        $display("FAIL %s frame%0d_length: got %0d cycles, required %0d", nm, k, nobs, ew.size());
      end
      bad = 0; first = -1;
      for (int t = 0; t < nobs && t < ew.size(); t++)
        if ({lg[st+t].er, lg[st+t].d} !== ew[t]) begin bad++; if (first < 0) first = t; end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s frame%0d_stream: byte %0d got er/txd %h, required %h (%0d wrong)",
                 nm, k, first, {lg[st+first].er, lg[st+first].d}, ew[first], bad);
      end
      eg = f.src ? 2'b10 : 2'b01;
      gb = 0;
      for (int t = st; t <= en_; t++) if (lg[t].gnt !== eg) gb++;
      checks++;
      if (gb != 0) begin
        errors++;
        $display("FAIL %s frame%0d_grant: got %b at start, required %b (%0d wrong)", nm, k, lg[st].gnt, eg, gb);
      end
      checks++;
      if (en_ + 1 >= lg.size() || lg[en_+1].fd !== 1'b1 || lg[en_+1].gnt !== 2'b00) begin
        errors++;
        $display("FAIL %s frame%0d_done: no frame_done/grant clear after last byte, required fd=1 grant=00", nm, k);
      end
      if (k > 0 && chk_gap) begin
        checks++;
        if (st - last_end - 1 != IPG) begin
          errors++;
          $display("FAIL %s frame%0d_gap: got %0d idle cycles, required %0d", nm, k, st - last_end - 1, IPG);
        end
      end
      if (k == 0 && chk_lat) begin
        checks++;
        if (st != 0) begin
          errors++;
          $display("FAIL %s first_preamble_latency: got sample %0d, required 0", nm, st);
        end
      end
      last_end = en_;
      k++;
    end
    fdn = 0;
    foreach (lg[t]) if (lg[t].fd) fdn++;
    checks++;
    if (k != ord.size() || fdn != ord.size()) begin
      errors++;
      $display("FAIL %s frame_count: got %0d frames %0d done pulses, required %0d", nm, k, fdn, ord.size());
    end
  endtask

  task automatic test_reset();
    mr_main_reset = 1'b0; transmitting = 1'b0;
    flush_srcs(); drive_srcs();
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(posedge GTX_CLK);
    #1;
    checks++; if (TX_EN !== 1'b0)      begin errors++; $display("FAIL reset_tx_en: got %b required 0", TX_EN); end
    checks++; if (TX_ER !== 1'b0)      begin errors++; $display("FAIL reset_tx_er: got %b required 0", TX_ER); end
    checks++; if (TXD !== 8'h00)       begin errors++; $display("FAIL reset_txd: got %h required 00", TXD); end
    checks++; if (grant !== 2'b00)     begin errors++; $display("FAIL reset_grant: got %b required 00", grant); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
    checks++; if (underrun !== 1'b0)   begin errors++; $display("FAIL reset_underrun: got %b required 0", underrun); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b required 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b required 0", req1_ready); end
  endtask

  task automatic test_single();
    int urn;
    apply_reset(); begin_run();
    load(mk(1'b0, 4, 8'h11, 8'h11));
    run(200);
    check_frames("single", 1'b1, 1'b1);
    urn = 0;
    foreach (lg[t]) if (lg[t].ur) urn++;
    checks++;
    if (urn != 0) begin errors++; $display("FAIL single_underrun: got %0d set cycles, required 0", urn); end
  endtask

  task automatic test_back_to_back();
    apply_reset(); begin_run();
    load(mk(1'b0, 2, 8'h61, 8'h01));
    load(mk(1'b1, 2, 8'h71, 8'h01));
    run(300);
    check_frames("back_to_back", 1'b1, 1'b1);
  endtask

  task automatic test_underrun();
    frame_t f;
    int u, bad;
    apply_reset(); begin_run();
    f = mk(1'b0, 4, 8'h81, 8'h01);
    f.g[2] = 2'd2;
    load(f);
    run(200);
    check_frames("underrun", 1'b1, 1'b1);
    repeat (15) cycle();
    u = -1;
    foreach (lg[t]) if (u < 0 && lg[t].er) u = t;
    checks++;
    if (u < 1 || lg[u-1].ur !== 1'b0) begin
      errors++; $display("FAIL underrun_onset: got first stall at sample %0d, required a clean frame start before it", u);
    end
    bad = 0;
    if (u >= 0) for (int t = u; t < lg.size(); t++) if (lg[t].ur !== 1'b1) bad++;
    checks++;
    if (u < 0 || bad != 0) begin errors++; $display("FAIL underrun_sticky: got %0d cleared cycles, required 0", bad); end
    begin_run();
    load(mk(1'b0, 2, 8'h91, 8'h01));
    run(200);
    check_frames("after_underrun", 1'b0, 1'b1);
    checks++;
    if (lg[0].ur !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b at next frame start, required 0", lg[0].ur); end
  endtask

  task automatic test_error();
    frame_t f;
    int ern;
    apply_reset(); begin_run();
    f = mk(1'b1, 5, 8'hE1, 8'h01);
    f.e[2] = 1'b1;
    load(f);
    run(200);
    check_frames("error", 1'b1, 1'b1);
    ern = 0;
    foreach (lg[t]) if (lg[t].er) ern++;
    checks++;
    if (ern != 1) begin errors++; $display("FAIL error_count: got %0d TX_ER cycles, required 1", ern); end
  endtask

  task automatic test_transmitting();
    int n, fdi, drop, enn;
    apply_reset(); begin_run();
    load(mk(1'b0, 3, 8'h31, 8'h01));
    load(mk(1'b0, 3, 8'h41, 8'h01));
    cycle(); cycle();
    transmitting = 1'b1;
    n = 0;
    while (n < 200 && !(lg.size() > 0 && lg[lg.size()-1].fd)) begin cycle(); n++; end
    fdi = lg.size() - 1;
    checks++;
    if (!lg[fdi].fd) begin errors++; $display("FAIL hold_first_done: got no frame_done within %0d cycles, required one", n); end
    repeat (20) cycle();
    transmitting = 1'b0;
    drop = lg.size();
    cycle();
    enn = 0;
    for (int t = fdi; t < drop; t++) if (lg[t].en) enn++;
    checks++;
    if (enn != 0) begin errors++; $display("FAIL hold_off: got %0d TX_EN cycles while busy, required 0", enn); end
    checks++;
    if (lg[drop].en !== 1'b1 || lg[drop].d !== 8'h55) begin
      errors++; $display("FAIL hold_release: got en=%b txd=%h after transmitting fell, required en=1 txd=55", lg[drop].en, lg[drop].d);
    end
    run(200);
    check_frames("transmitting", 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int n;
    bit found;
    apply_reset(); begin_run();
    load(mk(1'b0, 2, 8'h10, 8'h01));
    load(mk(1'b1, 6, 8'hA1, 8'h01));
    n = 0; found = 1'b0;
    while (n < 200 && !found) begin
      cycle(); n++;
      if (lg[lg.size()-1].en && lg[lg.size()-1].gnt == 2'b10 && lg[lg.size()-1].d == 8'hA3) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midreset_reach: got no src1 byte 3 within %0d cycles, required it", n); end
    #2;
    mr_main_reset = 1'b0;
    #1;
    checks++; if (TX_EN !== 1'b0)  begin errors++; $display("FAIL midreset_tx_en: got %b required 0", TX_EN); end
    checks++; if (TX_ER !== 1'b0)  begin errors++; $display("FAIL midreset_tx_er: got %b required 0", TX_ER); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL midreset_grant: got %b required 00", grant); end
    checks++; if (TXD !== 8'h00)   begin errors++; $display("FAIL midreset_txd: got %h required 00", TXD); end
    flush_srcs(); begin_run();
    model_ptr = 1'b0;
    load(mk(1'b1, 3, 8'hB1, 8'h01));
    load(mk(1'b0, 2, 8'hC1, 8'h01));
    drive_srcs();
    @(posedge GTX_CLK);
    #1;
    mr_main_reset = 1'b1;
    run(300);
    check_frames("post_reset", 1'b1, 1'b1);
  endtask

  task automatic test_random();
    frame_t f;
    int len;
    for (int it = 0; it < 2; it++) begin
      apply_reset(); begin_run();
      for (int k = 0; k < 3; k++) begin
        for (int s = 0; s < 2; s++) begin
          len = $urandom_range(1, 8);
          f = mk(s[0], len, 8'($urandom), 8'($urandom));
          for (int j = 0; j < len; j++) begin
            f.e[j] = ($urandom_range(0, 7) == 0);
            if (j > 0) f.g[j] = 2'($urandom_range(0, 2));
          end
          load(f);
        end
      end
      run(2000);
      check_frames("random", 1'b1, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mr_main_reset = 1'b0;
    transmitting  = 1'b0;
    flush_srcs();
    drive_srcs();
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_error();
    test_transmitting();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
